// File: rtl/cnn_accel_pkg.sv
// Shared constants and state encoding for the CNN accelerator tile engines.
package cnn_accel_pkg;

    // Default tile geometry and full output feature map size.
    localparam int TN_DEF = 16;
    localparam int TR_DEF = 64;
    localparam int TC_DEF = 16;
    localparam int R_DEF  = 128;
    localparam int C_DEF  = 128;

    // Derived sizes: words per tile, words per full-map channel plane, words per tile channel.
    localparam int TOTAL_DEF = TN_DEF * TR_DEF * TC_DEF;
    localparam int RC_DEF    = R_DEF * C_DEF;
    localparam int TRTC_DEF  = TR_DEF * TC_DEF;

    // Dump sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dump_state_e;

endpackage

// File: rtl/out_fm_skid_fifo.sv
// Two-entry FIFO holding {memory address, data} pairs returned from the out_fm buffer.
module out_fm_skid_fifo #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    // Storage, pointers and occupancy; clr empties the FIFO synchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: only two entries, and the stream data output must read zero
            // while in reset, so the storage is reset along with the pointers.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (clr) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            // Simultaneous push and pop leaves the count unchanged.
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/out_fm_dump.sv
// Drains one output-feature-map tile from the out_fm buffer onto an (addr, data) stream.
module out_fm_dump
    import cnn_accel_pkg::*;
#(
    parameter int AW  = 16,
    parameter int DW  = 32,
    parameter int MAW = 32,
    parameter int Tn  = TN_DEF,
    parameter int Tr  = TR_DEF,
    parameter int Tc  = TC_DEF,
    parameter int R   = R_DEF,
    parameter int C   = C_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           dump_start,
    input  logic           dump_tile_reset,
    input  logic [MAW-1:0] tile_base_addr,
    output logic           busy,
    output logic           dump_done,
    output logic           out_fm_rd_ena,
    output logic [AW-1:0]  out_fm_rd_addr,
    input  logic [DW-1:0]  out_fm_rd_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [DW-1:0]  m_data,
    output logic [MAW-1:0] m_addr
);

    localparam int             TOTAL    = Tn * Tr * Tc;
    localparam logic [AW-1:0]  LAST_IDX = AW'(TOTAL - 1);
    localparam logic [AW-1:0]  LAST_C   = AW'(Tc - 1);
    localparam logic [AW-1:0]  LAST_R   = AW'(Tr - 1);
    localparam logic [MAW-1:0] RC_STEP  = MAW'(R * C);
    localparam logic [MAW-1:0] C_STEP   = MAW'(C);

    dump_state_e    state_q;
    logic           dump_start_q;
    logic           busy_q;
    logic           done_q;
    logic [AW-1:0]  rd_cnt_q;
    logic [AW-1:0]  c_q;
    logic [AW-1:0]  r_q;
    logic [MAW-1:0] ch_base_q;
    logic [MAW-1:0] row_base_q;
    logic           inflight_q;
    logic [MAW-1:0] pipe_addr_q;

    logic           start_edge;
    logic           pop;
    logic           rd_fire;
    logic [2:0]     occ;
    logic [1:0]     fifo_count;
    logic [MAW+DW-1:0] fifo_dout;

    assign start_edge = dump_start & ~dump_start_q;
    assign pop        = m_valid & m_ready;
    assign occ        = {1'b0, fifo_count} + {2'b0, inflight_q};
    // Issue only while (buffered + in flight - leaving now) stays below the FIFO depth.
    assign rd_fire    = (state_q == ST_READ) && !dump_tile_reset &&
                        (occ < (3'd2 + {2'b0, pop}));

    // Registered copy of dump_start for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: state elements use non-blocking assignments so every flop
            // samples pre-edge values regardless of block evaluation order.
            dump_start_q <= 1'b0;
        end else begin
            dump_start_q <= dump_start;
        end
    end

    // Dump sequencer with registered busy and completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (dump_tile_reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        state_q <= ST_READ;
                        busy_q  <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (rd_fire && (rd_cnt_q == LAST_IDX)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Last word: the only one buffered, nothing left in flight.
                    if (pop && (fifo_count == 2'd1) && !inflight_q) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Linear buffer address plus multiplier-free memory address walk (c fastest, then r, then n).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q   <= '0;
            c_q        <= '0;
            r_q        <= '0;
            ch_base_q  <= '0;
            row_base_q <= '0;
        end else if (dump_tile_reset) begin
            rd_cnt_q   <= '0;
            c_q        <= '0;
            r_q        <= '0;
            ch_base_q  <= '0;
            row_base_q <= '0;
        end else if ((state_q == ST_IDLE) && start_edge) begin
            rd_cnt_q   <= '0;
            c_q        <= '0;
            r_q        <= '0;
            ch_base_q  <= tile_base_addr;
            row_base_q <= tile_base_addr;
        end else if (rd_fire) begin
            rd_cnt_q <= rd_cnt_q + AW'(1);
            if (c_q == LAST_C) begin
                c_q <= '0;
                if (r_q == LAST_R) begin
                    r_q        <= '0;
                    ch_base_q  <= ch_base_q + RC_STEP;
                    row_base_q <= ch_base_q + RC_STEP;
                end else begin
                    r_q        <= r_q + AW'(1);
                    row_base_q <= row_base_q + C_STEP;
                end
            end else begin
                c_q <= c_q + AW'(1);
            end
        end
    end

    // One-stage pipeline carrying the memory address alongside the buffer read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q  <= 1'b0;
            pipe_addr_q <= '0;
        end else if (dump_tile_reset) begin
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= rd_fire;
            if (rd_fire) begin
                pipe_addr_q <= row_base_q + MAW'(c_q);
            end
        end
    end

    out_fm_skid_fifo #(
        .W (MAW + DW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (dump_tile_reset),
        .push  (inflight_q),
        .din   ({pipe_addr_q, out_fm_rd_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign busy           = busy_q;
    assign dump_done      = done_q;
    assign out_fm_rd_ena  = rd_fire;
    assign out_fm_rd_addr = rd_cnt_q;
    assign m_valid        = (fifo_count != 2'd0);
    assign m_addr         = fifo_dout[MAW+DW-1:DW];
    assign m_data         = fifo_dout[DW-1:0];

endmodule

// File: tb/tb_out_fm_dump.sv
// Scoreboard bench for out_fm_dump on a small 2x2x3 tile inside a 4x5 map.
`timescale 1ns/1ps
module tb_out_fm_dump;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int MAW   = 32;
    localparam int TN    = 2;
    localparam int TR    = 2;
    localparam int TC    = 3;
    localparam int FR    = 4;
    localparam int FC    = 5;
    localparam int TOTAL = TN * TR * TC;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           dump_start = 1'b0;
    logic           dump_tile_reset = 1'b0;
    logic [MAW-1:0] tile_base_addr = '0;
    logic           busy;
    logic           dump_done;
    logic           out_fm_rd_ena;
    logic [AW-1:0]  out_fm_rd_addr;
    logic [DW-1:0]  out_fm_rd_data = '0;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [DW-1:0]  m_data;
    logic [MAW-1:0] m_addr;

    out_fm_dump #(
        .AW(AW), .DW(DW), .MAW(MAW),
        .Tn(TN), .Tr(TR), .Tc(TC), .R(FR), .C(FC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dump_start     (dump_start),
        .dump_tile_reset(dump_tile_reset),
        .tile_base_addr (tile_base_addr),
        .busy           (busy),
        .dump_done      (dump_done),
        .out_fm_rd_ena  (out_fm_rd_ena),
        .out_fm_rd_addr (out_fm_rd_addr),
        .out_fm_rd_data (out_fm_rd_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_addr         (m_addr)
    );

    always #5 clk = ~clk;

    // Buffer model: data appears one cycle after the read strobe.
    logic [DW-1:0] buf_mem [TOTAL];
    always @(posedge clk) begin
        if (out_fm_rd_ena) begin
            if (int'(out_fm_rd_addr) < TOTAL) out_fm_rd_data <= buf_mem[int'(out_fm_rd_addr)];
            else                              out_fm_rd_data <= '0;
        end
    end

    typedef struct packed {
        logic [MAW-1:0] addr;
        logic [DW-1:0]  data;
    } word_t;

    word_t          exp_q[$];
    int             n_vec = 0;
    int             n_miss = 0;
    int             rd_idx = 0;
    int             pop_idx = 0;
    int             done_count = 0;
    bit             done_expect = 0;
    bit             stall_q = 0;
    logic [MAW-1:0] stall_addr;
    logic [DW-1:0]  stall_data;
    int             ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fill_buf(input bit rnd);
        for (int i = 0; i < TOTAL; i++) buf_mem[i] = rnd ? $urandom() : DW'(i + 1000);
    endtask

    // Reference: every tile element at its place in the full map, n outer, c fastest.
    task automatic load_expected(input logic [MAW-1:0] base);
        word_t w;
        exp_q.delete();
        for (int n = 0; n < TN; n++)
            for (int r = 0; r < TR; r++)
                for (int c = 0; c < TC; c++) begin
                    w.addr = base + MAW'(n * FR * FC + r * FC + c);
                    w.data = buf_mem[n * TR * TC + r * TC + c];
                    exp_q.push_back(w);
                end
        rd_idx      = 0;
        pop_idx     = 0;
        done_expect = 0;
    endtask

    // Random back-pressure driver.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) m_ready = ($urandom_range(0, 1) == 1);
    end

    // Monitor: reads, handshakes, stalls and completion pulse.
    always @(negedge clk) begin
        word_t w;
        if (rst) begin
            if (done_expect) begin
                check("done_pulse", dump_done, 1);
                check("done_busy_low", busy, 0);
                done_expect = 0;
            end else begin
                check("no_stray_done", dump_done, 0);
            end
            if (dump_done) done_count++;
            if (stall_q) begin
                check("stall_valid", m_valid, 1);
                check("stall_addr", m_addr, stall_addr);
                check("stall_data", m_data, stall_data);
            end
            if (m_valid && m_ready && !dump_tile_reset) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL extra_word: got addr %0d with no word expected", m_addr);
                end else begin
                    w = exp_q.pop_front();
                    check("m_addr", m_addr, w.addr);
                    check("m_data", m_data, w.data);
                    pop_idx++;
                    if (exp_q.size() == 0) done_expect = 1;
                end
            end
            if (out_fm_rd_ena) begin
                check("rd_addr", out_fm_rd_addr, rd_idx);
                rd_idx++;
                check("outstanding_le_2", (rd_idx - pop_idx) <= 2, 1);
            end
            stall_q    = m_valid && !m_ready && !dump_tile_reset;
            stall_addr = m_addr;
            stall_data = m_data;
        end else begin
            stall_q     = 0;
            done_expect = 0;
        end
    end

    task automatic start_dump(input logic [MAW-1:0] base);
        @(posedge clk); #1;
        load_expected(base);
        tile_base_addr = base;
        dump_start     = 1'b1;
        @(posedge clk); #1;
        dump_start     = 1'b0;
        tile_base_addr = $urandom();
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (dump_done) return;
        end
        n_vec++;
        n_miss++;
        $display("FAIL done_timeout: got no dump_done within %0d cycles", max_cyc);
    endtask

    initial begin
        int first_rd, last_rd, first_valid, done_cyc, dc0;

        // Reset values.
        fill_buf(0);
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", dump_done, 0);
        check("rst_rd_ena", out_fm_rd_ena, 0);
        check("rst_rd_addr", out_fm_rd_addr, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_addr", m_addr, 0);
        @(negedge clk); #2;
        rst = 1'b1;

        // A: full throughput and latency.
        start_dump(100);
        first_rd = -1; last_rd = -1; first_valid = -1; done_cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("busy_after_start", busy, 1);
                check("rd_ena_cycle1", out_fm_rd_ena, 1);
            end
            if (out_fm_rd_ena) begin
                if (first_rd < 0) first_rd = i;
                last_rd = i;
            end
            if (m_valid && first_valid < 0) first_valid = i;
            if (dump_done) begin
                done_cyc = i;
                break;
            end
        end
        check("first_rd_cycle", first_rd, 1);
        check("last_rd_cycle", last_rd, 12);
        check("first_valid_cycle", first_valid, 3);
        check("done_cycle", done_cyc, 15);
        check("words_A", pop_idx, 12);

        // B: random back-pressure, random base and data.
        ready_mode = 1;
        for (int k = 0; k < 3; k++) begin
            fill_buf(1);
            start_dump($urandom());
            wait_done(400);
            repeat (3) @(negedge clk);
            check("words_B", pop_idx, TOTAL);
            check("reads_B", rd_idx, TOTAL);
        end
        ready_mode = 0;

        // C: held off for 20 cycles, only two reads issued.
        fill_buf(0);
        @(posedge clk); #1;
        m_ready = 1'b0;
        start_dump(100);
        repeat (20) @(negedge clk);
        check("stalled_reads", rd_idx, 2);
        check("stalled_valid", m_valid, 1);
        check("stalled_addr", m_addr, 100);
        check("stalled_data", m_data, 1000);
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_done(100);
        repeat (2) @(negedge clk);
        check("words_C", pop_idx, 12);

        // D: second start edge while busy is ignored.
        dc0 = done_count;
        start_dump(100);
        repeat (3) @(posedge clk);
        #1 dump_start = 1'b1;
        @(posedge clk); #1 dump_start = 1'b0;
        wait_done(100);
        repeat (20) @(negedge clk);
        check("single_done_D", done_count - dc0, 1);
        check("words_D", pop_idx, 12);
        check("reads_D", rd_idx, 12);

        // E: tile reset after five handshakes.
        dc0 = done_count;
        start_dump(100);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pop_idx >= 5) break;
        end
        check("abort_point", pop_idx, 5);
        @(posedge clk); #1 dump_tile_reset = 1'b1;
        @(posedge clk); #1 dump_tile_reset = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_valid", m_valid, 0);
        check("abort_rd_ena", out_fm_rd_ena, 0);
        repeat (10) @(negedge clk);
        check("abort_no_done", done_count - dc0, 0);
        start_dump(100);
        wait_done(100);
        repeat (2) @(negedge clk);
        check("words_E", pop_idx, 12);

        // F: asynchronous reset mid-dump.
        start_dump(100);
        repeat (6) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", dump_done, 0);
        check("arst_rd_ena", out_fm_rd_ena, 0);
        check("arst_rd_addr", out_fm_rd_addr, 0);
        check("arst_m_valid", m_valid, 0);
        check("arst_m_data", m_data, 0);
        check("arst_m_addr", m_addr, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        start_dump(100);
        wait_done(100);
        repeat (2) @(negedge clk);
        check("words_F", pop_idx, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/out_fm_dump.md
Name: out_fm_dump

Overview:
- Drains one finished output-feature-map tile from the on-chip out_fm buffer and streams it to the external-memory write path.
- Sits after the convolution control/data path. It reads the buffer that the convolution writes into, then emits (address, data) pairs on a valid/ready stream to the DDR write engine.
- Each pair is placed at its position in the full output feature map.

Parameters:
- AW, 16, out_fm buffer address width
- DW, 32, data width
- MAW, 32, external memory word-address width
- Tn, 16, output channels per tile
- Tr, 64, rows per tile
- Tc, 16, columns per tile
- R, 128, rows of full output feature map
- C, 128, columns of full output feature map

Ports:
- clk, in, 1, clock
- rst, in, 1, asynchronous active-low reset (asserted when 0)
- dump_start, in, 1, request; rising edge starts a dump
- dump_tile_reset, in, 1, synchronous abort/clear back to IDLE
- tile_base_addr, in, MAW, memory word address of tile element (n=0, r=0, c=0); sampled on start edge
- busy, out, 1, high from start edge to completion
- dump_done, out, 1, single-cycle completion pulse
- out_fm_rd_ena, out, 1, buffer read strobe
- out_fm_rd_addr, out, AW, buffer read address
- out_fm_rd_data, in, DW, buffer read data, valid exactly 1 cycle after out_fm_rd_ena
- m_valid, out, 1, stream valid
- m_ready, in, 1, stream ready
- m_data, out, DW, stream data
- m_addr, out, MAW, stream memory word address

Behaviour:
- Interface fixed: one clock clk; rst is asynchronous and active-low.
- Reset values: busy=0, dump_done=0, out_fm_rd_ena=0, out_fm_rd_addr=0, m_valid=0, m_data=0, m_addr=0. All counters and FIFO are empty/zero.
- TOTAL = Tn*Tr*Tc words. Traversal order is n outer, r middle, c inner (c fastest).
- Buffer address = linear count 0..TOTAL-1, i.e. n*Tr*Tc + r*Tc + c.
- Memory address = tile_base_addr + n*R*C + r*C + c. It is generated incrementally with no multipliers:
  - ch_base += R*C on channel wrap
  - row_base = ch_base on channel wrap, else row_base += C on row wrap
  - addr = row_base + c
  - All arithmetic is modulo 2^MAW.
- Start detection: start_edge = dump_start & ~dump_start_q, with dump_start_q a registered copy. An edge while busy=1 is ignored.
- FSM:
  - IDLE: on start_edge, latch base, go to READ, busy=1.
  - READ: issue reads under the credit rule below. After the read of word TOTAL-1 is issued, go to DRAIN.
  - DRAIN: no reads. When the handshake of word TOTAL-1 completes, go to DONE.
  - DONE: dump_done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
- Latency: start edge sampled at cycle 0 → out_fm_rd_ena=1 with addr 0 at cycle 1 → data captured at the end of cycle 2 → m_valid=1 at cycle 3.
- Buffering: a 2-entry FIFO holds returned read data plus its memory address. The address travels with the read through a 1-stage pipeline.
- Credit rule: issue a read in a cycle iff (fifo_count + inflight − pop_this_cycle) < 2.
  - pop = m_valid & m_ready.
  - Consequence: m_ready held high gives one word per cycle sustained; no word is ever dropped or duplicated.
- Stream rules:
  - m_data and m_addr stay stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake.
- Simultaneous push and pop on the FIFO: count unchanged; FIFO is never full on a push, by the credit rule.
- dump_tile_reset=1 has priority over everything:
  - FSM returns to IDLE; FIFO, counters and inflight are cleared.
  - busy=0, m_valid=0, out_fm_rd_ena=0 next cycle.
  - No dump_done pulse.
- Asynchronous reset mid-dump: all state is cleared immediately; the partial dump is lost.
- Edge case Tn=Tr=Tc=1: a single read; dump_done follows its handshake.

Decomposition:
- Shared package (cnn_accel_pkg) holds:
  - tile constants Tn/Tr/Tc, R/C
  - TOTAL and the R*C and Tr*Tc localparams
  - the FSM state encoding IDLE/READ/DRAIN/DONE
- One sub-module: out_fm_skid_fifo.
  - Ports: clk, rst (active-low async), clr, push, din, pop, dout, count.
  - 2 entries; carries {addr, data}.

Test Plan (Tn=2, Tr=2, Tc=3, R=4, C=5, TOTAL=12, base=100, buffer preloaded with data=addr+1000):
- Start with m_ready=1 → rd_ena cycles 1..12. m_addr sequence is 100,101,102,105,106,107,120,121,122,125,126,127, with matching data 1000..1011 on consecutive cycles. dump_done pulses one cycle after the last handshake.
- Random m_ready (50%) → same 12 (addr,data) pairs, in order, none lost or duplicated. Outputs are stable while stalled and FIFO count never exceeds 2.
- m_ready=0 for 20 cycles after start → exactly 2 reads issued (addr 0,1), m_valid held with m_addr=100. Releasing m_ready completes a normal dump.
- Second start edge while busy → ignored; exactly 12 words and one dump_done.
- dump_tile_reset asserted after 5 handshakes → busy=0 and m_valid=0 the next cycle, no dump_done. A new start produces all 12 words from addr 100.
- rst low mid-dump (async, between edges) → all outputs 0 immediately. After release, a restart produces the full, correct sequence.
